// File: rtl/xctrl_ack.sv
`default_nettype none
// ============================================================================
// Module      : xctrl_ack
// Description : Accumulator micro-controller with a req/ack bus handshake.
//               One instruction per cycle in EXEC; bus accesses park the core
//               in BUS_WAIT until rw_ack. Optional shifter: XCTRL_SHIFT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module xctrl_ack #(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 8,
  parameter int ADDR_W = 8,
  parameter int PC_W   = 10,
  localparam int OPC_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [PC_W-1:0]        pc,
  input  logic [OPC_W+IMM_W-1:0] instruction,
  input  logic                   instr_valid,
  output logic                   rw_req,
  output logic                   rw_rnw,
  output logic [ADDR_W-1:0]      rw_addr,
  output logic [DATA_W-1:0]      data_to_wr,
  input  logic                   rw_ack,
  input  logic [DATA_W-1:0]      data_to_rd
);

  localparam logic [OPC_W-1:0] c_OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] c_OP_LDI   = 4'h1;
  localparam logic [OPC_W-1:0] c_OP_ADDI  = 4'h2;
  localparam logic [OPC_W-1:0] c_OP_RDW   = 4'h3;
  localparam logic [OPC_W-1:0] c_OP_WRW   = 4'h4;
  localparam logic [OPC_W-1:0] c_OP_ADD   = 4'h5;
  localparam logic [OPC_W-1:0] c_OP_SUB   = 4'h6;
  localparam logic [OPC_W-1:0] c_OP_BEQI  = 4'h7;
  localparam logic [OPC_W-1:0] c_OP_BNEQI = 4'h8;
`ifdef XCTRL_SHIFT_EN
  localparam logic [OPC_W-1:0] c_OP_SHL   = 4'h9;
  localparam logic [OPC_W-1:0] c_OP_SHR   = 4'hA;
`endif

  localparam logic [DATA_W:0]  c_ONE    = {{DATA_W{1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]  c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_EXEC     = 1'b0,
    S_BUS_WAIT = 1'b1
  } state_t;

  state_t             r_state,      w_state_nxt;
  logic [PC_W-1:0]    r_pc,         w_pc_nxt;
  logic [DATA_W-1:0]  r_reg_a,      w_reg_a_nxt;
  logic               r_reg_c,      w_reg_c_nxt;
  logic               r_rw_req,     w_rw_req_nxt;
  logic               r_rw_rnw,     w_rw_rnw_nxt;
  logic [ADDR_W-1:0]  r_rw_addr,    w_rw_addr_nxt;
  logic [DATA_W-1:0]  r_data_to_wr, w_data_to_wr_nxt;
  logic [OPC_W-1:0]   r_bus_opc,    w_bus_opc_nxt;
  logic               w_do_arith;

  logic [OPC_W-1:0]   w_opc;
  logic [IMM_W-1:0]   w_imm;
  logic [DATA_W-1:0]  w_imm_data;
  logic [PC_W-1:0]    w_imm_pc;
  logic               w_is_local;
  logic [DATA_W-1:0]  w_local_op;
  logic               w_in_bus;
  logic [OPC_W-1:0]   w_arith_opc;
  logic [DATA_W-1:0]  w_operand;
  logic [DATA_W:0]    w_add_sum;
  logic [DATA_W:0]    w_sub_sum;
  logic [DATA_W:0]    w_addi_sum;
  logic [PC_W-1:0]    w_pc_inc;
  logic [PC_W-1:0]    w_pc_br;

  assign w_opc = instruction[OPC_W+IMM_W-1 -: OPC_W];
  assign w_imm = instruction[IMM_W-1:0];

  // Immediate resized to the data path: sign-extend when wider, truncate otherwise.
  generate
    if (DATA_W > IMM_W) begin : g_data_pad
      assign w_imm_data = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    end else begin : g_data_cut
      assign w_imm_data = w_imm[DATA_W-1:0];
    end
  endgenerate

  // Immediate resized to the program counter for branch offsets.
  generate
    if (PC_W > IMM_W) begin : g_pc_pad
      assign w_imm_pc = {{(PC_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    end else begin : g_pc_cut
      assign w_imm_pc = w_imm[PC_W-1:0];
    end
  endgenerate

  // Operand addresses 0 and 1 alias the internal registers, no bus cycle.
  assign w_is_local = (w_imm == IMM_W'(0)) || (w_imm == IMM_W'(1));
  assign w_local_op = w_imm[0] ? {{(DATA_W-1){1'b0}}, r_reg_c} : r_reg_a;

  // One shared arithmetic path: local operand in EXEC, bus data at ack.
  assign w_in_bus    = (r_state == S_BUS_WAIT);
  assign w_arith_opc = w_in_bus ? r_bus_opc  : w_opc;
  assign w_operand   = w_in_bus ? data_to_rd : w_local_op;
  assign w_add_sum   = {1'b0, r_reg_a} + {1'b0, w_operand};
  assign w_sub_sum   = {1'b0, r_reg_a} + {1'b0, ~w_operand} + c_ONE;
  assign w_addi_sum  = {1'b0, r_reg_a} + {1'b0, w_imm_data};
  assign w_pc_inc    = r_pc + c_PC_ONE;
  assign w_pc_br     = r_pc + w_imm_pc;

  // State, architectural registers and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EXEC;
      r_pc         <= '0;
      r_reg_a      <= '0;
      r_reg_c      <= 1'b0;
      r_rw_req     <= 1'b0;
      r_rw_rnw     <= 1'b1;
      r_rw_addr    <= '0;
      r_data_to_wr <= '0;
      r_bus_opc    <= c_OP_NOP;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_reg_a      <= w_reg_a_nxt;
      r_reg_c      <= w_reg_c_nxt;
      r_rw_req     <= w_rw_req_nxt;
      r_rw_rnw     <= w_rw_rnw_nxt;
      r_rw_addr    <= w_rw_addr_nxt;
      r_data_to_wr <= w_data_to_wr_nxt;
      r_bus_opc    <= w_bus_opc_nxt;
    end
  end

  // Instruction decode, bus handshake sequencing and next-register values.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_reg_a_nxt      = r_reg_a;
    w_reg_c_nxt      = r_reg_c;
    w_rw_req_nxt     = r_rw_req;
    w_rw_rnw_nxt     = r_rw_rnw;
    w_rw_addr_nxt    = r_rw_addr;
    w_data_to_wr_nxt = r_data_to_wr;
    w_bus_opc_nxt    = r_bus_opc;
    w_do_arith       = 1'b0;

    case (r_state)
      S_EXEC: begin
        if (instr_valid) begin
          w_pc_nxt = w_pc_inc;
          case (w_opc)
            c_OP_NOP: ;
            c_OP_LDI:  w_reg_a_nxt = w_imm_data;
            c_OP_ADDI: {w_reg_c_nxt, w_reg_a_nxt} = w_addi_sum;
            c_OP_RDW, c_OP_ADD, c_OP_SUB: begin
              if (w_is_local) begin
                w_do_arith = 1'b1;
              end else begin
                w_state_nxt      = S_BUS_WAIT;
                w_rw_req_nxt     = 1'b1;
                w_rw_rnw_nxt     = 1'b1;
                w_rw_addr_nxt    = w_imm[ADDR_W-1:0];
                w_data_to_wr_nxt = r_reg_a;
                w_bus_opc_nxt    = w_opc;
                w_pc_nxt         = r_pc;
              end
            end
            c_OP_WRW: begin
              w_state_nxt      = S_BUS_WAIT;
              w_rw_req_nxt     = 1'b1;
              w_rw_rnw_nxt     = 1'b0;
              w_rw_addr_nxt    = w_imm[ADDR_W-1:0];
              w_data_to_wr_nxt = r_reg_a;
              w_bus_opc_nxt    = w_opc;
              w_pc_nxt         = r_pc;
            end
            c_OP_BEQI:  if (r_reg_a == '0) w_pc_nxt = w_pc_br;
            c_OP_BNEQI: if (r_reg_a != '0) w_pc_nxt = w_pc_br;
`ifdef XCTRL_SHIFT_EN
            c_OP_SHL: {w_reg_c_nxt, w_reg_a_nxt} = {r_reg_a, 1'b0};
            c_OP_SHR: {w_reg_a_nxt, w_reg_c_nxt} = {1'b0, r_reg_a};
`endif
            default: ;
          endcase
        end
      end
      S_BUS_WAIT: begin
        // Bus fields stay frozen; the instruction stream is ignored here.
        if (rw_ack) begin
          w_state_nxt  = S_EXEC;
          w_rw_req_nxt = 1'b0;
          w_pc_nxt     = w_pc_inc;
          w_do_arith   = r_rw_rnw;
        end
      end
      default: w_state_nxt = S_EXEC;
    endcase

    if (w_do_arith) begin
      case (w_arith_opc)
        c_OP_RDW: w_reg_a_nxt = w_operand;
        c_OP_ADD: {w_reg_c_nxt, w_reg_a_nxt} = w_add_sum;
        c_OP_SUB: {w_reg_c_nxt, w_reg_a_nxt} = w_sub_sum;
        default: ;
      endcase
    end
  end

  assign pc         = r_pc;
  assign rw_req     = r_rw_req;
  assign rw_rnw     = r_rw_rnw;
  assign rw_addr    = r_rw_addr;
  assign data_to_wr = r_data_to_wr;

endmodule
`default_nettype wire
